// File: rtl/risc_v_mike_pkg.sv
// Shared load-path definitions: funct3 load encodings, read-response FSM states
// and load legality helpers.
package risc_v_mike_pkg;

   localparam logic [2:0] LOAD_LB  = 3'b000;
   localparam logic [2:0] LOAD_LH  = 3'b001;
   localparam logic [2:0] LOAD_LW  = 3'b010;
   localparam logic [2:0] LOAD_LBU = 3'b100;
   localparam logic [2:0] LOAD_LHU = 3'b101;

   localparam int MMIO_TIMEOUT_DEF = 16;

   typedef enum logic [1:0] {IDLE, WAIT_RAM, WAIT_MMIO, RESP} rd_rsp_state_t;

   function automatic logic load_illegal(input logic [2:0] funct3);
      return (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
   endfunction

   function automatic logic load_misaligned(input logic [2:0] funct3, input logic [1:0] off);
      logic mis;
      mis = 1'b0;
      case (funct3)
         LOAD_LH, LOAD_LHU: mis = off[0];
         LOAD_LW:           mis = (off != 2'b00);
         default:           mis = 1'b0;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/risc_v_load_align.sv
// Combinational load aligner: shifts the word to the addressed byte lane and
// sign/zero-extends by load type. Shared with the instruction-side path.
module risc_v_load_align
   import risc_v_mike_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  off,
   input  logic [2:0]  funct3,
   output logic [31:0] result
);

   logic [31:0] shifted;

   always_comb begin
      shifted = word >> {off, 3'b000};
      case (funct3)
         LOAD_LB:  result = {{24{shifted[7]}}, shifted[7:0]};
         LOAD_LH:  result = {{16{shifted[15]}}, shifted[15:0]};
         LOAD_LBU: result = {24'h0, shifted[7:0]};
         LOAD_LHU: result = {16'h0, shifted[15:0]};
         default:  result = word;
      endcase
   end

endmodule

// File: rtl/risc_v_mem_rd_rsp.sv
// Data-bus read-response path: waits on the selected region, aligns the word and
// returns one response per request. MEM_RD_MMIO_TIMEOUT_EN enables the MMIO timeout.
module risc_v_mem_rd_rsp
   import risc_v_mike_pkg::*;
#(
   parameter int RAM_RD_LAT   = 1,
   parameter int MMIO_TIMEOUT = MMIO_TIMEOUT_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mem_bus_read,
   input  logic [2:0]  rd_funct3,
   input  logic [1:0]  rd_byte_off,
   input  logic        data_stack_rd_addr_val,
   input  logic        data_mem_rd_addr_val,
   input  logic        data_mmio_rd_addr_val,
   input  logic        mem_bus_rd_addr_error,
   input  logic [31:0] data_stack_rd_data,
   input  logic [31:0] data_mem_rd_data,
   input  logic [31:0] data_mmio_rd_data,
   input  logic        data_mmio_rd_ready,
   output logic [31:0] mem_bus_rd_data,
   output logic        mem_bus_rd_valid,
   output logic        mem_bus_rd_resp_err,
   output logic        mem_bus_rd_stall
);

   localparam logic [1:0] RAM_CNT_INIT = 2'(RAM_RD_LAT - 1);

   rd_rsp_state_t state, state_nxt;
   logic [1:0]    lat_cnt, lat_cnt_nxt;
   logic          sel_stack, sel_stack_nxt;
   logic [2:0]    f3_q, f3_nxt;
   logic [1:0]    off_q, off_nxt;
   logic          err_q, err_nxt;
   logic [31:0]   word_q, word_nxt;
   logic          req_err;
   logic [31:0]   aligned;

`ifdef MEM_RD_MMIO_TIMEOUT_EN
   localparam logic [7:0] MMIO_LAST = 8'(MMIO_TIMEOUT - 1);
   logic [7:0] mmio_cnt, mmio_cnt_nxt;
`endif

   // A request that selects no region is treated like an unmapped address.
   assign req_err = mem_bus_rd_addr_error | load_illegal(rd_funct3)
                  | load_misaligned(rd_funct3, rd_byte_off)
                  | ~(data_stack_rd_addr_val | data_mem_rd_addr_val | data_mmio_rd_addr_val);

   always_comb begin
      state_nxt     = state;
      lat_cnt_nxt   = lat_cnt;
      sel_stack_nxt = sel_stack;
      f3_nxt        = f3_q;
      off_nxt       = off_q;
      err_nxt       = err_q;
      word_nxt      = word_q;
`ifdef MEM_RD_MMIO_TIMEOUT_EN
      mmio_cnt_nxt  = mmio_cnt;
`endif
      case (state)
         IDLE: begin
            if (mem_bus_read) begin
               f3_nxt        = rd_funct3;
               off_nxt       = rd_byte_off;
               sel_stack_nxt = data_stack_rd_addr_val;
               err_nxt       = req_err;
               word_nxt      = '0;
               if (req_err) begin
                  state_nxt = RESP;
               end else if (data_stack_rd_addr_val | data_mem_rd_addr_val) begin
                  state_nxt   = WAIT_RAM;
                  lat_cnt_nxt = RAM_CNT_INIT;
               end else begin
                  state_nxt = WAIT_MMIO;
`ifdef MEM_RD_MMIO_TIMEOUT_EN
                  mmio_cnt_nxt = '0;
`endif
               end
            end
         end
         WAIT_RAM: begin
            if (lat_cnt == 2'd0) begin
               word_nxt  = sel_stack ? data_stack_rd_data : data_mem_rd_data;
               state_nxt = RESP;
            end else begin
               lat_cnt_nxt = lat_cnt - 2'd1;
            end
         end
         WAIT_MMIO: begin
            if (data_mmio_rd_ready) begin
               word_nxt  = data_mmio_rd_data;
               state_nxt = RESP;
`ifdef MEM_RD_MMIO_TIMEOUT_EN
            end else if (mmio_cnt == MMIO_LAST) begin
               err_nxt   = 1'b1;
               state_nxt = RESP;
            end else begin
               mmio_cnt_nxt = mmio_cnt + 8'd1;
`endif
            end
         end
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         lat_cnt   <= '0;
         sel_stack <= 1'b0;
         f3_q      <= '0;
         off_q     <= '0;
         err_q     <= 1'b0;
         word_q    <= '0;
`ifdef MEM_RD_MMIO_TIMEOUT_EN
         mmio_cnt  <= '0;
`endif
      end else begin
         state     <= state_nxt;
         lat_cnt   <= lat_cnt_nxt;
         sel_stack <= sel_stack_nxt;
         f3_q      <= f3_nxt;
         off_q     <= off_nxt;
         err_q     <= err_nxt;
         word_q    <= word_nxt;
`ifdef MEM_RD_MMIO_TIMEOUT_EN
         mmio_cnt  <= mmio_cnt_nxt;
`endif
      end
   end

   risc_v_load_align u_align (
      .word   (word_q),
      .off    (off_q),
      .funct3 (f3_q),
      .result (aligned)
   );

   assign mem_bus_rd_valid    = (state == RESP);
   assign mem_bus_rd_resp_err = mem_bus_rd_valid & err_q;
   assign mem_bus_rd_data     = (mem_bus_rd_valid & ~err_q) ? aligned : 32'h0;
   // Held low during reset so every output reads 0 while rst_n is asserted.
   assign mem_bus_rd_stall    = rst_n & ((state != IDLE) | mem_bus_read);

endmodule

// File: tb/tb_risc_v_mem_rd_rsp.sv
// Directed bench for risc_v_mem_rd_rsp: a transaction-level model predicts the
// response cycle, data and error; a single negedge process compares every cycle.
module tb_risc_v_mem_rd_rsp;

   localparam int LAT = 1;
   localparam int TMO = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        mem_bus_read = 1'b0;
   logic [2:0]  rd_funct3 = 3'b0;
   logic [1:0]  rd_byte_off = 2'b0;
   logic        stack_val = 1'b0, mem_val = 1'b0, mmio_val = 1'b0, addr_err = 1'b0;
   logic [31:0] stack_word = 32'h0, mem_word = 32'h0, mmio_bus = 32'h0;
   logic        mmio_ready = 1'b0;
   logic [31:0] rd_data;
   logic        rd_valid, rd_err, rd_stall;

   logic [31:0] mmio_word = 32'h0;

   risc_v_mem_rd_rsp #(.RAM_RD_LAT(LAT), .MMIO_TIMEOUT(TMO)) dut (
      .clk                    (clk),
      .rst_n                  (rst_n),
      .mem_bus_read           (mem_bus_read),
      .rd_funct3              (rd_funct3),
      .rd_byte_off            (rd_byte_off),
      .data_stack_rd_addr_val (stack_val),
      .data_mem_rd_addr_val   (mem_val),
      .data_mmio_rd_addr_val  (mmio_val),
      .mem_bus_rd_addr_error  (addr_err),
      .data_stack_rd_data     (stack_word),
      .data_mem_rd_data       (mem_word),
      .data_mmio_rd_data      (mmio_bus),
      .data_mmio_rd_ready     (mmio_ready),
      .mem_bus_rd_data        (rd_data),
      .mem_bus_rd_valid       (rd_valid),
      .mem_bus_rd_resp_err    (rd_err),
      .mem_bus_rd_stall       (rd_stall)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // expectation of the transaction in flight
   bit          pend = 1'b0;
   int          acc_cyc = 0, exp_cyc = 0;
   logic [31:0] exp_data = 32'h0;
   bit          exp_err = 1'b0;
   bit          lit_en = 1'b0;
   logic [31:0] lit_data = 32'h0;
   bit          lit_err = 1'b0;

   int ntests = 0, nfail = 0;

   function automatic logic [31:0] model_load(input logic [31:0] w, input int off, input int f3);
      logic [31:0] s, v;
      s = w >> (8 * off);
      case (f3)
         0: begin v = s % 256;   if (v >= 128)   v = v - 32'd256;   end
         1: begin v = s % 65536; if (v >= 32768) v = v - 32'd65536; end
         4: v = s % 256;
         5: v = s % 65536;
         default: v = w;
      endcase
      return v;
   endfunction

   function automatic bit model_err(input int f3, input int off, input bit aerr, input logic [2:0] sel);
      int size;
      if (aerr || sel == 3'b000) return 1'b1;
      if (f3 == 3 || f3 >= 6) return 1'b1;
      size = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
      return (off % size) != 0;
   endfunction

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      ntests++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s @cyc %0d: got %h, expected %h", nm, cyc, act, exp);
      end
   endfunction

   always @(negedge clk) begin
      logic        ev, es;
      logic [31:0] ed;
      if (!rst_n) begin
         chk("rst_valid", {31'b0, rd_valid}, 32'h0);
         chk("rst_err",   {31'b0, rd_err},   32'h0);
         chk("rst_data",  rd_data,           32'h0);
         chk("rst_stall", {31'b0, rd_stall}, 32'h0);
      end else begin
         ev = pend && (cyc == exp_cyc);
         es = pend && (cyc >= acc_cyc) && (cyc <= exp_cyc);
         ed = (ev && !exp_err) ? exp_data : 32'h0;
         chk("valid", {31'b0, rd_valid}, {31'b0, ev});
         chk("stall", {31'b0, rd_stall}, {31'b0, es});
         chk("err",   {31'b0, rd_err},   {31'b0, ev && exp_err});
         chk("data",  rd_data,           ed);
         if (ev && lit_en) begin
            chk("lit_data", rd_data, lit_data);
            chk("lit_err",  {31'b0, rd_err}, {31'b0, lit_err});
         end
      end
   end

   // One request; mdly = cycles after acceptance at which MMIO ready is raised.
   task automatic do_req(input logic [2:0] sel, input logic [2:0] f3, input logic [1:0] off,
                         input bit aerr, input int mdly, input bit chk_lit,
                         input logic [31:0] ldata, input bit lerr);
      int          lat;
      bit          e, is_mmio;
      logic [31:0] w;
      e = model_err(f3, off, aerr, sel);
      is_mmio = !sel[0] && !sel[1] && sel[2];
      w = sel[0] ? stack_word : sel[1] ? mem_word : mmio_word;
      if (e) lat = 1;
      else if (!is_mmio) lat = LAT + 1;
`ifdef MEM_RD_MMIO_TIMEOUT_EN
      else if (mdly > TMO) begin lat = TMO + 1; e = 1'b1; end
`endif
      else lat = mdly + 1;
      @(posedge clk); #1;
      acc_cyc  = cyc;
      exp_cyc  = cyc + lat;
      exp_err  = e;
      exp_data = e ? 32'h0 : model_load(w, off, f3);
      lit_en   = chk_lit; lit_data = ldata; lit_err = lerr;
      pend     = 1'b1;
      mem_bus_read = 1'b1; rd_funct3 = f3; rd_byte_off = off; addr_err = aerr;
      {mmio_val, mem_val, stack_val} = sel;
      // ready during the acceptance cycle must be ignored
      mmio_ready = 1'b1; mmio_bus = ~mmio_word;
      for (int k = 0; k <= lat; k++) begin
         @(posedge clk); #1;
         mem_bus_read = 1'b0; addr_err = 1'b0; {mmio_val, mem_val, stack_val} = 3'b000;
         if (is_mmio && !e && cyc == acc_cyc + mdly) begin
            mmio_ready = 1'b1; mmio_bus = mmio_word;
         end else begin
            mmio_ready = 1'b0; mmio_bus = 32'h0;
         end
      end
      pend = 1'b0; lit_en = 1'b0; mmio_ready = 1'b0;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (2) @(posedge clk);

      mem_word = 32'h8765_4321;
      do_req(3'b010, 3'b010, 2'd0, 1'b0, 0, 1'b1, 32'h8765_4321, 1'b0);
      stack_word = 32'h0000_80FF;
      do_req(3'b001, 3'b000, 2'd1, 1'b0, 0, 1'b1, 32'hFFFF_FF80, 1'b0);
      do_req(3'b001, 3'b100, 2'd1, 1'b0, 0, 1'b1, 32'h0000_0080, 1'b0);
      do_req(3'b001, 3'b101, 2'd0, 1'b0, 0, 1'b1, 32'h0000_80FF, 1'b0);
      do_req(3'b001, 3'b001, 2'd0, 1'b0, 0, 1'b1, 32'hFFFF_80FF, 1'b0);
      do_req(3'b001, 3'b000, 2'd0, 1'b0, 0, 1'b1, 32'hFFFF_FFFF, 1'b0);
      do_req(3'b010, 3'b001, 2'd2, 1'b0, 0, 1'b1, 32'hFFFF_8765, 1'b0);
      do_req(3'b011, 3'b010, 2'd0, 1'b0, 0, 1'b1, 32'h0000_80FF, 1'b0);
      do_req(3'b010, 3'b010, 2'd2, 1'b0, 0, 1'b1, 32'h0, 1'b1);
      do_req(3'b010, 3'b011, 2'd0, 1'b0, 0, 1'b1, 32'h0, 1'b1);
      do_req(3'b001, 3'b101, 2'd1, 1'b0, 0, 1'b1, 32'h0, 1'b1);
      do_req(3'b010, 3'b010, 2'd0, 1'b1, 0, 1'b1, 32'h0, 1'b1);

      mmio_word = 32'hDEAD_BEEF;
      do_req(3'b100, 3'b010, 2'd0, 1'b0, 5, 1'b1, 32'hDEAD_BEEF, 1'b0);
      do_req(3'b100, 3'b100, 2'd3, 1'b0, 1, 1'b1, 32'h0000_00DE, 1'b0);
      do_req(3'b100, 3'b010, 2'd0, 1'b0, TMO, 1'b1, 32'hDEAD_BEEF, 1'b0);
      do_req(3'b100, 3'b010, 2'd0, 1'b0, TMO + 4, 1'b0, 32'h0, 1'b0);

      // reset while waiting on MMIO drops the transaction
      @(posedge clk); #1;
      acc_cyc = cyc; exp_cyc = cyc + 1000; exp_err = 1'b0; exp_data = 32'h0; lit_en = 1'b0;
      pend = 1'b1;
      mem_bus_read = 1'b1; mmio_val = 1'b1; rd_funct3 = 3'b010; rd_byte_off = 2'd0;
      @(posedge clk); #1;
      mem_bus_read = 1'b0; mmio_val = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b0; pend = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (4) @(posedge clk);
      mem_word = 32'h1234_5678;
      do_req(3'b010, 3'b010, 2'd0, 1'b0, 0, 1'b1, 32'h1234_5678, 1'b0);

      repeat (2) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
